rv_mdu: RTL and testbench

- Iterative, parametrised multiply/divide unit implementing all eight RV32M/RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside rv_alu in the execute stage. Uses a req/ready/valid handshake so the pipeline stalls while it is busy.
- Result is registered and stays stable until the next accepted request.
- Extends the single-cycle ALU with multi-cycle sequential datapaths, signed/unsigned mode handling, RISC-V corner-case results, and a pipeline-flush input.

---
 rtl/rv_mdu.sv | 153 +++++++++++++++
 tb/tb_rv_mdu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, with RISC-V divide-by-zero/overflow results and flush.
module rv_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            mdu_req_i,
  input  logic [2:0]      mdu_op_i,
  input  logic [XLEN-1:0] mdu_port_a_i,
  input  logic [XLEN-1:0] mdu_port_b_i,
  input  logic            mdu_kill_i,
  output logic            mdu_ready_o,
  output logic            mdu_valid_o,
  output logic [XLEN-1:0] mdu_result_o
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic            accept;
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, early;
  logic [XLEN-1:0] early_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff, div_rem;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] iter_next, prod_s;
  logic [XLEN-1:0]   quo, rem, fin_res;

  assign accept = mdu_req_i & mdu_ready_o & ~mdu_kill_i;

  // Operand decode at accept: magnitudes, result sign and the RISC-V shortcut cases
  always_comb begin
    a_sgn    = (mdu_op_i == OP_MULH) | (mdu_op_i == OP_MULHSU) |
               (mdu_op_i == OP_DIV)  | (mdu_op_i == OP_REM);
    b_sgn    = (mdu_op_i == OP_MULH) | (mdu_op_i == OP_DIV) | (mdu_op_i == OP_REM);
    a_neg    = a_sgn & mdu_port_a_i[XLEN-1];
    b_neg    = b_sgn & mdu_port_b_i[XLEN-1];
    a_mag    = a_neg ? -mdu_port_a_i : mdu_port_a_i;
    b_mag    = b_neg ? -mdu_port_b_i : mdu_port_b_i;
    div_zero = mdu_op_i[2] & (mdu_port_b_i == '0);
    div_ovf  = mdu_op_i[2] & ~mdu_op_i[0] &
               (mdu_port_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (&mdu_port_b_i);
    early    = div_zero | div_ovf;
    if (div_zero) early_res = mdu_op_i[1] ? mdu_port_a_i : '1;
    else          early_res = mdu_op_i[1] ? '0 : mdu_port_a_i;
  end

  // One iteration of either core; acc holds {hi, lo} (mul) or {rem, dividend/quotient} (div)
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_shift[XLEN] | (div_shift[XLEN-1:0] >= opnd_q);
    div_diff  = div_shift[XLEN-1:0] - opnd_q;
    div_rem   = div_ge ? div_diff : div_shift[XLEN-1:0];
    div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};
    iter_next = op_q[2] ? div_next : mul_next;
    prod_s    = neg_q ? -iter_next : iter_next;
    quo       = iter_next[XLEN-1:0];
    rem       = iter_next[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       fin_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fin_res = neg_q ? -quo : quo;
      default:                      fin_res = neg_q ? -rem : rem;
    endcase
  end

  // State register and datapath flops
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = early ? DONE : CALC;
      CALC:    if (mdu_kill_i) state_d = IDLE;
               else if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mdu_ready_o  = (state_q == IDLE);
    mdu_valid_o  = (state_q == DONE) & ~mdu_kill_i;
    mdu_result_o = result_q;
  end

  always_comb begin
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (state_q == IDLE && accept) begin
      op_d   = mdu_op_i;
      acc_d  = {{XLEN{1'b0}}, mdu_op_i[2] ? a_mag : b_mag};
      opnd_d = mdu_op_i[2] ? b_mag : a_mag;
      neg_d  = (mdu_op_i == OP_REM) ? a_neg : (a_neg ^ b_neg);
      if (early) result_d = early_res;
      else       cnt_d    = CW'(XLEN-1);
    end else if (state_q == CALC && !mdu_kill_i) begin
      acc_d = iter_next;
      if (cnt_q == '0) result_d = fin_res;
      else             cnt_d    = cnt_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_rv_mdu.sv
// Bench for rv_mdu: directed table, kill/reset sequences and random ops
// against a behavioural reference model, checked through a result scoreboard.
module tb_rv_mdu;
  localparam int XLEN = 32;

  logic             clk = 1'b0, rstn = 1'b0, req = 1'b0, kill = 1'b0;
  logic [2:0]       op = '0;
  logic [XLEN-1:0]  a = '0, b = '0;
  logic             ready, valid;
  logic [XLEN-1:0]  res;

  always #5 clk = ~clk;

  rv_mdu #(.XLEN(XLEN)) dut (
    .clk_i(clk), .rstn_i(rstn), .mdu_req_i(req), .mdu_op_i(op),
    .mdu_port_a_i(a), .mdu_port_b_i(b), .mdu_kill_i(kill),
    .mdu_ready_o(ready), .mdu_valid_o(valid), .mdu_result_o(res)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;

  int          n_chk = 0, n_fail = 0, n_done = 0, cyc = 0, valid_cyc = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_exp = '0;
  vec_t        tbl[16];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, p;
    logic [63:0]        ux, uy, up;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      3'd0: begin up = ux * uy; return up[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * $signed(uy); return p[63:32]; end
      3'd3: begin up = ux * uy; return up[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        p = sx / sy; return p[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        p = sx % sy; return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and service the output side of the scoreboard
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    if (rstn && valid) begin
      valid_cyc = cyc;
      n_done++;
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got result %h with no request outstanding", res);
      end else begin
        e = sb_q.pop_front();
        chk("result", res, e);
        last_exp = e;
      end
    end
  endtask

  task automatic accept(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit push, input logic [31:0] exp, output int c0);
    int k = 0;
    while (!ready && k < 60) begin step(); k++; end
    if (!ready) chk("ready_timeout", {31'b0, ready}, 32'h1);
    op = o; a = x; b = y; req = 1'b1;
    c0 = cyc;
    if (push) sb_q.push_back(exp);
    step();
    req = 1'b0;
    op = 3'($urandom_range(0, 7));
    a = $urandom;
    b = $urandom;
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp, input int lat);
    int c0, k, d0;
    d0 = n_done;
    accept(o, x, y, 1'b1, exp, c0);
    k = 0;
    while (n_done == d0 && k < 60) begin step(); k++; end
    if (n_done == d0) begin
      chk("valid_timeout", 32'h0, 32'h1);
      sb_q.delete();
    end else if (lat > 0) begin
      chk("latency", 32'(valid_cyc - c0), 32'(lat));
    end
  endtask

  task automatic kill_after(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int d);
    int c0;
    accept(o, x, y, 1'b0, '0, c0);
    repeat (d - 1) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_ready", {31'b0, ready}, 32'h1);
    chk("kill_hold", res, last_exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          c0;
    bit          early;

    tbl[0]  = '{3'd0, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 33};
    tbl[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    tbl[2]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    tbl[4]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33};
    tbl[5]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    tbl[6]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    tbl[7]  = '{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 33};
    tbl[8]  = '{3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 33};
    tbl[9]  = '{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    tbl[10] = '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
    tbl[11] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[12] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    tbl[13] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    tbl[14] = '{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
    tbl[15] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33};

    // Reset state
    step(); step();
    chk("rst_ready", {31'b0, ready}, 32'h1);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_result", res, 32'h0);
    rstn = 1'b1;
    step();

    foreach (tbl[i]) run(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

    // Flush mid-divide, then the unit must take new work immediately
    kill_after(3'd5, 32'hDEAD_BEEF, 32'h0000_0123, 10);
    repeat (40) step();
    run(3'd0, 32'h3, 32'h3, 32'h9, 33);

    // Kill together with a request in IDLE: not accepted
    op = 3'd0; a = 32'h1; b = 32'h1; req = 1'b1; kill = 1'b1;
    step();
    req = 1'b0; kill = 1'b0;
    chk("kill_idle_ready", {31'b0, ready}, 32'h1);
    repeat (40) step();

    // Reset mid-CALC
    accept(3'd0, 32'h5, 32'h5, 1'b0, '0, c0);
    repeat (5) step();
    rstn = 1'b0;
    step();
    chk("rst_mid_ready", {31'b0, ready}, 32'h1);
    chk("rst_mid_result", res, 32'h0);
    chk("rst_mid_valid", {31'b0, valid}, 32'h0);
    rstn = 1'b1;
    last_exp = '0;
    repeat (40) step();
    run(3'd5, 32'd100, 32'd7, 32'd14, 33);

    // Random ops with occasional flush during CALC
    for (int n = 0; n < 1000; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = ($urandom_range(0, 9) == 0) ? 32'h0 : pick();
      early = ro[2] && (rb == 0 || (!ro[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF));
      if (!early && $urandom_range(0, 7) == 0)
        kill_after(ro, ra, rb, int'($urandom_range(1, 32)));
      else
        run(ro, ra, rb, ref_mdu(ro, ra, rb), early ? 1 : 33);
    end
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
